// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready and
// shifts it out on B, one bit per DIV clocks, with strobe/busy/done status.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             B,
  output logic             Bit_Strobe,
  output logic             Busy,
  output logic             Done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-2:0] rest_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [DW-1:0]    div_cnt_q;
  logic             b_q;
  logic             strobe_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic             accept_d;

  // Normalise bit order at capture so the shifter always sends word_d MSB first.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
    if (MSB_FIRST) begin : g_msb
      assign word_d[gi] = Din[gi];
    end else begin : g_lsb
      assign word_d[gi] = Din[WIDTH-1-gi];
    end
  end

  assign accept_d = Load_Valid & ready_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      rest_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      b_q       <= IDLE_LEVEL;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept_d) begin
            state_q   <= SHIFT;
            rest_q    <= word_d[WIDTH-2:0];
            b_q       <= word_d[WIDTH-1];
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            strobe_q  <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            state_q  <= IDLE;
            b_q      <= IDLE_LEVEL;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_q   <= DONE;
              bit_cnt_q <= '0;
              b_q       <= IDLE_LEVEL;
              strobe_q  <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              ready_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              b_q       <= rest_q[WIDTH-2];
              rest_q    <= rest_q << 1;
              strobe_q  <= 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DW'(1);
            strobe_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          rest_q    <= '0;
          bit_cnt_q <= '0;
          div_cnt_q <= '0;
          b_q       <= IDLE_LEVEL;
          strobe_q  <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign Load_Ready = ready_q;
  assign B          = b_q;
  assign Bit_Strobe = strobe_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializer configurations (DIV=4 MSB first, DIV=1 LSB
// first) driven by directed and random words, checked cycle by cycle.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lv  = 2'b11;
  logic [7:0] din [2];
  logic [1:0] ready, b, strb, busy, done;

  exp_t exp_q [2][$];
  int   m_left  [2] = '{0, 0};
  bit   m_ready [2] = '{1'b1, 1'b1};
  bit   started     = 1'b0;
  bit   final_chk   = 1'b0;
  bit   final_done  = 1'b0;
  int   n_checks    = 0;
  int   n_errors    = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
    .Clk(clk), .Rst(rst), .Din(din[0]), .Load_Valid(lv[0]), .Load_Ready(ready[0]),
    .B(b[0]), .Bit_Strobe(strb[0]), .Busy(busy[0]), .Done(done[0])
  );

  bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut1 (
    .Clk(clk), .Rst(rst), .Din(din[1]), .Load_Valid(lv[1]), .Load_Ready(ready[1]),
    .B(b[1]), .Bit_Strobe(strb[1]), .Busy(busy[1]), .Done(done[1])
  );

  function automatic int div_of(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic bit msb_of(int u);
    return (u == 0);
  endfunction

  // Reference model: a word accepted at an edge yields WIDTH*DIV shift cycles
  // then one Done cycle; readiness returns on that Done cycle.
  always @(posedge clk) begin
    started = 1'b1;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        exp_q[u].delete();
        m_left[u]  = 0;
        m_ready[u] = 1'b1;
      end else if (lv[u] && m_ready[u]) begin
        for (int i = 0; i < 8; i++) begin
          int   idx;
          exp_t e;
          idx = msb_of(u) ? (7 - i) : i;
          for (int j = 0; j < div_of(u); j++) begin
            e.b = din[u][idx];
            e.s = (j == 0);
            e.d = 1'b0;
            exp_q[u].push_back(e);
          end
        end
        exp_q[u].push_back(exp_t'(3'b001));
        m_left[u]  = 8 * div_of(u);
        m_ready[u] = 1'b0;
      end else if (m_left[u] > 0) begin
        m_left[u] = m_left[u] - 1;
        if (m_left[u] == 0) m_ready[u] = 1'b1;
      end
    end
  end

  // Monitor: pops one expected entry whenever a DUT is shifting or signalling Done.
  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (ready[u] !== m_ready[u]) begin
          n_errors++;
          $display("FAIL load_ready dut%0d: got %b, expected %b (t=%0t)", u, ready[u], m_ready[u], $time);
        end
        n_checks++;
        if (busy[u] !== (m_left[u] > 0)) begin
          n_errors++;
          $display("FAIL busy dut%0d: got %b, expected %b (t=%0t)", u, busy[u], (m_left[u] > 0), $time);
        end
        n_checks++;
        if (busy[u] || done[u]) begin
          if (exp_q[u].size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output dut%0d: got b/strobe/done=%b%b%b, expected idle (t=%0t)",
                     u, b[u], strb[u], done[u], $time);
          end else begin
            exp_t e;
            e = exp_q[u].pop_front();
            if ({b[u], strb[u], done[u]} !== e) begin
              n_errors++;
              $display("FAIL serial_out dut%0d: got b/strobe/done=%b%b%b, expected %b%b%b (t=%0t)",
                       u, b[u], strb[u], done[u], e.b, e.s, e.d, $time);
            end
          end
        end else if ({b[u], strb[u]} !== 2'b00) begin
          n_errors++;
          $display("FAIL idle_out dut%0d: got b/strobe=%b%b, expected 00 (t=%0t)", u, b[u], strb[u], $time);
        end
      end
      if (final_chk && !final_done) begin
        final_done = 1'b1;
        for (int u = 0; u < 2; u++) begin
          n_checks++;
          if (exp_q[u].size() != 0) begin
            n_errors++;
            $display("FAIL drain dut%0d: got %0d pending entries, expected 0", u, exp_q[u].size());
          end
        end
      end
    end
  end

  initial begin
    din[0] = 8'h3C;
    din[1] = 8'hC3;
    // Reset held two clocks with Load_Valid high: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lv = 2'b00;

    // DIV=4 MSB first, word B0, with a rejected FF pulse at cycle k+10.
    @(posedge clk); #1;
    lv[0] = 1'b1; din[0] = 8'hB0;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 lv[0] = 1'b1; din[0] = 8'hFF;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    repeat (30) @(posedge clk);

    // DIV=1 LSB first, back-to-back 0D then A5 through the Done cycle.
    #1 lv[1] = 1'b1; din[1] = 8'h0D;
    @(posedge clk); #1;
    din[1] = 8'hA5;
    repeat (9) @(posedge clk);
    #1 lv[1] = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in cycle k+3 of a DIV=1 transfer.
    #1 lv[1] = 1'b1; din[1] = 8'h5A;
    @(posedge clk); #1;
    lv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      for (int u = 0; u < 2; u++) begin
        lv[u]  = ($urandom_range(0, 2) == 0);
        din[u] = 8'($urandom);
      end
    end

    @(posedge clk); #1;
    rst = 1'b0;
    lv  = 2'b00;
    repeat (40) @(posedge clk);
    #1 final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
